// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory bus: IDLE -> BUSY -> RESP.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: data wins).
`ifndef RW
`define RW 16
`endif

module mem_arbiter (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_f_req,
   input  logic [`RW-1:0] i_f_addr,
   output logic           o_f_ack,
   output logic [`RW-1:0] o_f_data,
   input  logic           i_d_req,
   input  logic           i_d_we,
   input  logic [`RW-1:0] i_d_addr,
   input  logic [`RW-1:0] i_d_data,
   output logic           o_d_ack,
   output logic [`RW-1:0] o_d_data,
   input  logic           i_flush,
   output logic           o_mem_req,
   output logic           o_mem_we,
   output logic [`RW-1:0] o_mem_addr,
   output logic [`RW-1:0] o_mem_data,
   input  logic           i_mem_ack,
   input  logic [`RW-1:0] i_mem_data
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {OWN_F, OWN_D} owner_t;

   state_t         state_q, state_d;
   owner_t         owner_q, owner_d;
   owner_t         pick;
   logic           cancel_q, cancel_d;
   logic           we_q, we_d;
   logic [`RW-1:0] addr_q, addr_d;
   logic [`RW-1:0] wdata_q, wdata_d;
   logic [`RW-1:0] rdata_q, rdata_d;
   logic           any_req;
`ifdef MEM_ARB_RR_EN
   owner_t         last_q, last_d;
`endif

   assign any_req = i_f_req | i_d_req;

   always_comb begin
`ifdef MEM_ARB_RR_EN
      if (i_f_req && i_d_req) begin
         pick = (last_q == OWN_D) ? OWN_F : OWN_D;
      end else if (i_d_req) begin
         pick = OWN_D;
      end else begin
         pick = OWN_F;
      end
`else
      pick = i_d_req ? OWN_D : OWN_F;
`endif
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cancel_d  = cancel_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
`ifdef MEM_ARB_RR_EN
      last_d    = last_q;
`endif
      o_mem_req = 1'b0;
      o_f_ack   = 1'b0;
      o_d_ack   = 1'b0;

      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (any_req) begin
               owner_d = pick;
               state_d = BUSY;
`ifdef MEM_ARB_RR_EN
               last_d  = pick;
`endif
               if (pick == OWN_D) begin
                  we_d    = i_d_we;
                  addr_d  = i_d_addr;
                  wdata_d = i_d_data;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = i_f_addr;
                  wdata_d = '0;
               end
            end
         end
         BUSY: begin
            o_mem_req = 1'b1;
            if (i_flush && owner_q == OWN_F) begin
               cancel_d = 1'b1;
            end
            if (i_mem_ack) begin
               rdata_d = i_mem_data;
               state_d = RESP;
            end
         end
         RESP: begin
            // A flush landing in RESP itself must also swallow the fetch ack.
            if (owner_q == OWN_D) begin
               o_d_ack = 1'b1;
            end else begin
               o_f_ack = ~(cancel_q | i_flush);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_F;
         cancel_q <= 1'b0;
         we_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q   <= OWN_F;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cancel_q <= cancel_d;
         we_q     <= we_d;
`ifdef MEM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
   end

   assign o_mem_we   = we_q & (state_q == BUSY);
   assign o_mem_addr = addr_q;
   assign o_mem_data = wdata_q;
   assign o_f_data   = rdata_q;
   assign o_d_data   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a grant-order model feeds expected bus and ack queues.
`timescale 1ns/1ps
`ifndef RW
`define RW 16
`endif

module tb_mem_arbiter;
   localparam int W = `RW;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, f_req, d_req, d_we, flush;
   logic [W-1:0] f_addr, d_addr, d_data;
   logic         f_ack, d_ack, mem_req, mem_we;
   logic [W-1:0] f_rdata, d_rdata, mem_addr, mem_wdata;
   logic         rsp_ack, stray_ack, mem_ack;
   logic [W-1:0] rsp_data, stray_data, mem_rdata;

   assign mem_ack   = rsp_ack | stray_ack;
   assign mem_rdata = stray_ack ? stray_data : rsp_data;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_data(f_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_data(d_data),
      .o_d_ack(d_ack), .o_d_data(d_rdata), .i_flush(flush),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
      .i_mem_ack(mem_ack), .i_mem_data(mem_rdata)
   );

   typedef struct { bit we; logic [W-1:0] addr; logic [W-1:0] data; } txn_t;
   typedef struct { bit port_d; bit is_write; logic [W-1:0] data; } ack_t;

   int unsigned checks = 0, fails = 0;
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [W-1:0] dflt(input logic [W-1:0] a);
      return (a << 3) ^ ~a;
   endfunction

   // Reference memory and expectation queues
   logic [W-1:0] ref_mem [logic [W-1:0]];
   logic [W-1:0] phys_mem [logic [W-1:0]];
   txn_t bus_q[$];
   ack_t ack_q[$];
   txn_t fl[$], dl[$];
   bit   model_last_d = 1'b0;

   // Grant order from the arbitration rules: both ports stay pending until one list runs dry.
   task automatic plan();
      int fi = 0, di = 0;
      bit take_d;
      txn_t t;
      logic [W-1:0] rv;
      while (fi < fl.size() || di < dl.size()) begin
         if (fi < fl.size() && di < dl.size()) take_d = RR ? !model_last_d : 1'b1;
         else take_d = (di < dl.size());
         if (take_d) begin t = dl[di]; di++; end
         else begin t = fl[fi]; fi++; end
         model_last_d = take_d;
         bus_q.push_back(t);
         rv = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
         if (t.we) ref_mem[t.addr] = t.data;
         ack_q.push_back('{take_d, t.we, rv});
      end
   endtask

   // Monitor: pops expected acks
   bit f_acked = 1'b0, d_acked = 1'b0;
   int ack_cycles[$];
   ack_t mon_e;
   always @(negedge clk) begin
      if (f_ack || d_ack) begin
         chk("ack_onehot", {30'd0, f_ack, d_ack} == 32'd3, 0);
         if (ack_q.size() == 0) begin
            chk("unexpected_ack", {30'd0, f_ack, d_ack}, 0);
         end else begin
            mon_e = ack_q.pop_front();
            chk("ack_port", d_ack, mon_e.port_d);
            if (!mon_e.is_write) chk("ack_data", d_ack ? d_rdata : f_rdata, mon_e.data);
         end
         ack_cycles.push_back(cyc);
         if (f_ack) f_acked = 1'b1;
         if (d_ack) d_acked = 1'b1;
      end
   end

   // Memory responder: checks bus fields and answers after a delay
   int   resp_delay = 0;
   bit   resp_rand = 1'b0;
   int   busy_cnt = 0, cur_delay = 0, busy_len_last = 0, mem_ack_cyc = 0;
   bit   rsp_unstable = 1'b0;
   txn_t rsp_first, rsp_exp;
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         if (busy_cnt == 0) begin
            cur_delay    = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
            rsp_first    = '{mem_we, mem_addr, mem_wdata};
            rsp_unstable = 1'b0;
            if (bus_q.size() == 0) begin
               chk("unexpected_bus", 1, 0);
            end else begin
               rsp_exp = bus_q.pop_front();
               chk("bus_we", mem_we, rsp_exp.we);
               chk("bus_addr", mem_addr, rsp_exp.addr);
               if (rsp_exp.we) chk("bus_wdata", mem_wdata, rsp_exp.data);
            end
         end else if (mem_we !== rsp_first.we || mem_addr !== rsp_first.addr ||
                      mem_wdata !== rsp_first.data) begin
            rsp_unstable = 1'b1;
         end
         if (busy_cnt == cur_delay) begin
            rsp_ack     = 1'b1;
            rsp_data    = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
            if (mem_we) phys_mem[mem_addr] = mem_wdata;
            mem_ack_cyc = cyc;
         end else begin
            rsp_ack = 1'b0;
         end
         busy_cnt++;
      end else begin
         if (busy_cnt != 0) begin
            busy_len_last = busy_cnt;
            chk("bus_stable", rsp_unstable, 0);
         end
         busy_cnt = 0;
         rsp_ack  = 1'b0;
      end
   end

   task automatic run_f();
      foreach (fl[i]) begin
         f_addr = fl[i].addr; f_req = 1'b1; f_acked = 1'b0;
         for (int t = 0; t < 100 && !f_acked; t++) begin @(posedge clk); #1; end
         chk("fetch_ack_seen", f_acked, 1);
      end
      f_req = 1'b0;
   endtask

   task automatic run_d();
      foreach (dl[i]) begin
         d_we = dl[i].we; d_addr = dl[i].addr; d_data = dl[i].data; d_req = 1'b1; d_acked = 1'b0;
         for (int t = 0; t < 100 && !d_acked; t++) begin @(posedge clk); #1; end
         chk("data_ack_seen", d_acked, 1);
      end
      d_req = 1'b0; d_we = 1'b0;
   endtask

   int burst_start = 0;
   task automatic burst();
      plan();
      @(posedge clk); #1;
      burst_start = cyc;
      ack_cycles.delete();
      fork
         run_f();
         run_d();
      join
      repeat (3) @(posedge clk);
      #1;
      chk("ack_q_drained", ack_q.size(), 0);
      chk("bus_q_drained", bus_q.size(), 0);
      fl.delete(); dl.delete();
   endtask

   task automatic wait_busy(input string name);
      for (int t = 0; t < 20 && !mem_req; t++) begin @(posedge clk); #1; end
      chk(name, mem_req, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
      f_addr = '0; d_addr = '0; d_data = '0;
      rsp_ack = 1'b0; rsp_data = '0; stray_ack = 1'b0; stray_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_req", mem_req, 0);
      chk("reset_f_ack", f_ack, 0);
      chk("reset_d_ack", d_ack, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single fetch, zero-wait memory
      ref_mem[16'h0010] = 16'hABCD; phys_mem[16'h0010] = 16'hABCD;
      resp_delay = 0;
      fl.push_back('{1'b0, 16'h0010, '0});
      burst();
      chk("fetch_latency", ack_cycles[0] - burst_start, 2);

      // Both ports continuously requesting
      for (int i = 0; i < 4; i++) begin
         fl.push_back('{1'b0, W'(16'h0100 + i), '0});
         dl.push_back('{1'b0, W'(16'h0300 + i), '0});
      end
      burst();
      chk("burst_first_ack", ack_cycles[0] - burst_start, 2);
      for (int i = 1; i < ack_cycles.size(); i++)
         chk("burst_ack_spacing", ack_cycles[i] - ack_cycles[i-1], 3);

      // Delayed write then read-back
      resp_delay = 5;
      dl.push_back('{1'b1, 16'h0200, 16'h1234});
      burst();
      chk("wr_busy_len", busy_len_last, 6);
      chk("wr_ack_after_mem", ack_cycles[0] - mem_ack_cyc, 1);
      resp_delay = 1;
      dl.push_back('{1'b0, 16'h0200, '0});
      burst();

      // Flush cancels an in-flight fetch
      resp_delay = 2;
      bus_q.push_back('{1'b0, 16'h0040, '0});
      model_last_d = 1'b0;
      @(posedge clk); #1;
      f_addr = 16'h0040; f_req = 1'b1; f_acked = 1'b0;
      wait_busy("flush_busy_reached");
      flush = 1'b1; f_req = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("flush_no_fack", f_acked, 0);
      chk("flush_idle", mem_req, 0);
      chk("flush_bus_done", bus_q.size(), 0);
      dl.push_back('{1'b0, 16'h0044, '0});
      burst();

      // Flush has no effect on data transactions
      flush = 1'b1;
      dl.push_back('{1'b1, 16'h0050, 16'h5A5A});
      dl.push_back('{1'b0, 16'h0050, '0});
      burst();
      flush = 1'b0;

      // Reset mid-transaction, then a stray memory ack in IDLE
      resp_delay = 10;
      bus_q.push_back('{1'b0, 16'h0080, '0});
      @(posedge clk); #1;
      f_addr = 16'h0080; f_req = 1'b1; f_acked = 1'b0;
      wait_busy("rst_busy_reached");
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req_low", mem_req, 0);
      chk("rst_no_f_ack", f_ack, 0);
      @(posedge clk); #1;
      rst = 1'b0; f_req = 1'b0;
      model_last_d = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      stray_data = W'($urandom); stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_ack_ignored", mem_req, 0);
      end
      chk("rst_no_ack", f_acked, 0);
      resp_delay = 0;
      fl.push_back('{1'b0, 16'h0090, '0});
      dl.push_back('{1'b0, 16'h0094, '0});
      burst();

      // Randomized rounds
      resp_rand = 1'b1;
      for (int r = 0; r < 25; r++) begin
         int nf = int'($urandom_range(0, 3));
         int nd = int'($urandom_range(0, 3));
         for (int i = 0; i < nf; i++) fl.push_back('{1'b0, W'($urandom_range(0, 15)), '0});
         for (int i = 0; i < nd; i++)
            dl.push_back('{1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom)});
         burst();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
